// File: rtl/usb_phy_tx.sv
// USB full-speed PHY transmit serializer: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, plus a bit-stuff-error abort on cancel or underrun.
module usb_phy_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_lp_sop,
    input  logic       tx_lp_eop,
    input  logic       tx_lp_valid,
    output logic       tx_lp_ready,
    input  logic [7:0] tx_lp_data,
    input  logic       tx_lp_cancle,
    output logic       dp_o,
    output logic       dm_o,
    output logic       d_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J, ABORT} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;      // bit position inside SYNC, EOP_SE0 and ABORT
    logic [2:0]    bits_left;    // data bits of the current byte not yet on the line
    logic [7:0]    shift_reg;
    logic [7:0]    hold_reg;
    logic          hold_v;
    logic          eop_accepted;
    logic          cancel_pend;
    logic          ready_en;
    logic [2:0]    ones_cnt;
    logic          level;        // NRZI line level currently driven, 1 = J

    logic strobe, sync_done, stuff, byte_end, abort_req, load, emit;
    logic next_bit, next_lvl;

    assign strobe    = (state != IDLE) && (bit_cnt == CW'(CLK_PER_BIT - 1));
    assign sync_done = (bit_idx == 3'd7);
    assign stuff     = (ones_cnt == 3'd6);
    assign byte_end  = (bits_left == 3'd0) && !stuff;
    assign abort_req = cancel_pend || tx_lp_cancle;

    // load: a new byte moves from the holding register into the shifter.
    // emit: the next SYNC/data/stuff bit goes on the line at this edge.
    assign load = strobe && !abort_req && hold_v &&
                  ((state == SYNC && sync_done) || (state == DATA && byte_end));
    assign emit = load || (strobe && !abort_req &&
                  ((state == SYNC && !sync_done) || (state == DATA && !byte_end)));

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        next_bit = 1'b0;
        case (state)
            SYNC: next_bit = sync_done ? hold_reg[0] : (bit_idx == 3'd6);
            DATA: begin
                if (stuff)
                    next_bit = 1'b0;
                else if (bits_left != 3'd0)
                    next_bit = shift_reg[0];
                else
                    next_bit = hold_reg[0];
            end
            default: next_bit = 1'b0;
        endcase
        next_lvl = next_bit ? level : !level;
    end

    always_comb begin
        tx_lp_ready = 1'b0;
        case (state)
            IDLE:       tx_lp_ready = ready_en;
            SYNC, DATA: tx_lp_ready = ready_en && !hold_v && !eop_accepted && !cancel_pend;
            default:    tx_lp_ready = 1'b0;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the byte registers are reset too, so a mid-packet reset leaves no stale data.
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= 3'd0;
            bits_left    <= 3'd0;
            shift_reg    <= 8'h00;
            hold_reg     <= 8'h00;
            hold_v       <= 1'b0;
            eop_accepted <= 1'b0;
            cancel_pend  <= 1'b0;
            ready_en     <= 1'b0;
            ones_cnt     <= 3'd0;
            level        <= 1'b1;
            dp_o         <= 1'b1;
            dm_o         <= 1'b0;
            d_oe         <= 1'b0;
            tx_busy      <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            tx_underrun <= 1'b0;

            if (state == IDLE || strobe)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;

            if (emit) begin
                level    <= next_lvl;
                dp_o     <= next_lvl;
                dm_o     <= !next_lvl;
                ones_cnt <= next_bit ? ones_cnt + 3'd1 : 3'd0;
            end

            case (state)
                IDLE: begin
                    // Non-sop beats are accepted by ready and simply dropped here.
                    if (tx_lp_valid && tx_lp_ready && tx_lp_sop) begin
                        state        <= SYNC;
                        hold_reg     <= tx_lp_data;
                        hold_v       <= 1'b1;
                        eop_accepted <= tx_lp_eop;
                        cancel_pend  <= 1'b0;
                        ones_cnt     <= 3'd0;
                        bit_idx      <= 3'd0;
                        level        <= 1'b0;
                        dp_o         <= 1'b0;
                        dm_o         <= 1'b1;
                        d_oe         <= 1'b1;
                        tx_busy      <= 1'b1;
                    end
                end

                SYNC, DATA: begin
                    if (tx_lp_cancle) begin
                        hold_v      <= 1'b0;
                        cancel_pend <= 1'b1;
                    end else if (tx_lp_valid && tx_lp_ready) begin
                        hold_reg     <= tx_lp_data;
                        hold_v       <= 1'b1;
                        eop_accepted <= tx_lp_eop;
                    end

                    if (strobe) begin
                        if (abort_req) begin
                            state   <= ABORT;
                            bit_idx <= 3'd0;
                        end else if (load) begin
                            state     <= DATA;
                            shift_reg <= {1'b0, hold_reg[7:1]};
                            bits_left <= 3'd7;
                            hold_v    <= 1'b0;
                        end else if (emit) begin
                            if (state == SYNC) begin
                                bit_idx <= bit_idx + 3'd1;
                            end else if (!stuff) begin
                                shift_reg <= {1'b0, shift_reg[7:1]};
                                bits_left <= bits_left - 3'd1;
                            end
                        end else if (state == DATA && eop_accepted) begin
                            state   <= EOP_SE0;
                            bit_idx <= 3'd0;
                            dp_o    <= 1'b0;
                            dm_o    <= 1'b0;
                        end else begin
                            state       <= ABORT;
                            bit_idx     <= 3'd0;
                            tx_underrun <= 1'b1;
                        end
                    end
                end

                ABORT: begin
                    // Seven bit times of unchanged level violate the stuffing rule on purpose.
                    if (strobe) begin
                        if (bit_idx == 3'd6) begin
                            state   <= EOP_SE0;
                            bit_idx <= 3'd0;
                            dp_o    <= 1'b0;
                            dm_o    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                EOP_SE0: begin
                    if (strobe) begin
                        if (bit_idx == 3'd1) begin
                            state <= EOP_J;
                            dp_o  <= 1'b1;
                            dm_o  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                EOP_J: begin
                    if (strobe) begin
                        state        <= IDLE;
                        d_oe         <= 1'b0;
                        tx_busy      <= 1'b0;
                        level        <= 1'b1;
                        hold_v       <= 1'b0;
                        eop_accepted <= 1'b0;
                        cancel_pend  <= 1'b0;
                        ones_cnt     <= 3'd0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_phy_tx.sv
// Self-checking bench for usb_phy_tx: a bit-stream model (stuff, NRZI, abort, EOP)
// predicts the line symbol of every bit time and is compared each clock.
module tb_usb_phy_tx;
    localparam int N = 4;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sop = 1'b0, eop = 1'b0, valid = 1'b0, cancel = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, dp, dm, oe, busy, underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = -1;

    logic [7:0] mbytes[$];
    logic [1:0] exp_sym[$];
    int         abort_first;

    usb_phy_tx #(.CLK_PER_BIT(N)) dut (
        .clk(clk), .rst(rst),
        .tx_lp_sop(sop), .tx_lp_eop(eop), .tx_lp_valid(valid), .tx_lp_ready(ready),
        .tx_lp_data(data), .tx_lp_cancle(cancel),
        .dp_o(dp), .dm_o(dm), .d_oe(oe), .tx_busy(busy), .tx_underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    // Line symbols per bit time for mbytes. cut >= 0 aborts after stuffed bit 'cut';
    // abort_end aborts after the last data bit instead of sending an EOP directly.
    task automatic build_model(input int cut, input bit abort_end);
        bit         raw[$];
        bit         st[$];
        int         ones;
        int         c;
        logic       lvl;
        logic [7:0] v;
        raw = {};
        st = {};
        exp_sym = {};
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        foreach (mbytes[b]) begin
            v = mbytes[b];
            for (int i = 0; i < 8; i++) raw.push_back(v[i]);
        end
        ones = 0;
        foreach (raw[i]) begin
            st.push_back(raw[i]);
            if (raw[i]) begin
                ones++;
                if (ones == 6) begin
                    st.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        c = abort_end ? st.size() - 1 : cut;
        if (c >= 0)
            while (st.size() > c + 1) st.delete(st.size() - 1);
        lvl = 1'b1;
        foreach (st[i]) begin
            if (!st[i]) lvl = !lvl;
            exp_sym.push_back(lvl ? J : K);
        end
        abort_first = (c >= 0) ? exp_sym.size() : 100000;
        if (c >= 0) repeat (7) exp_sym.push_back(lvl ? J : K);
        exp_sym.push_back(SE0);
        exp_sym.push_back(SE0);
        exp_sym.push_back(J);
    endtask

    function automatic string sym_str();
        string s = "";
        foreach (exp_sym[i]) begin
            case (exp_sym[i])
                J:       s = {s, "J"};
                K:       s = {s, "K"};
                default: s = {s, "0"};
            endcase
        end
        return s;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        int w = 0;
        data = d; sop = s; eop = e; valid = 1'b1;
        while (!ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (s && start_cyc < 0) start_cyc = cyc;
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int w = 0;
        do begin
            @(negedge clk); #1;
            w++;
        end while (start_cyc < 0 && w < 400);
        ok = (start_cyc >= 0);
    endtask

    // ready_mode: 0 unchecked, 1 low for the whole packet, 2 low from the abort on.
    task automatic check_line(input bit exp_ur, input int ready_mode);
        bit          ok;
        int          off, bi, total;
        logic [4:0]  exp;
        wait_start(ok);
        if (!ok) begin
            check("start_timeout", 32'd0, 32'd1);
            return;
        end
        total = exp_sym.size();
        forever begin
            off = cyc - start_cyc;
            if (off >= total * N + 4) break;
            bi = off / N;
            if (bi < total)
                exp = {1'b1, exp_sym[bi], 1'b1, exp_ur && (off == abort_first * N)};
            else
                exp = {1'b0, J, 1'b0, 1'b0};
            check($sformatf("line off=%0d {oe,dp,dm,busy,ur}", off),
                  {oe, dp, dm, busy, underrun}, exp);
            if (bi < total && ((ready_mode == 1) || (ready_mode == 2 && bi >= abort_first)))
                check($sformatf("ready_low off=%0d", off), ready, 1'b0);
            @(negedge clk); #1;
        end
    endtask

    task automatic pulse_cancel(input int at_off);
        bit ok;
        wait_start(ok);
        if (!ok) return;
        while (cyc - start_cyc < at_off) begin
            @(negedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk); #1;
        cancel = 1'b0;
    endtask

    task automatic run(input bit last_eop, input int cancel_off, input bit abort_end,
                       input bit exp_ur, input int ready_mode);
        build_model(cancel_off >= 0 ? cancel_off / N : -1, abort_end);
        start_cyc = -1;
        fork
            begin
                for (int i = 0; i < mbytes.size(); i++)
                    send_beat(mbytes[i], i == 0, last_eop && (i == mbytes.size() - 1));
            end
            check_line(exp_ur, ready_mode);
            begin
                if (cancel_off >= 0) pulse_cancel(cancel_off);
            end
        join
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset {dp,dm,oe,busy,ur,ready}", {dp, dm, oe, busy, underrun, ready}, 6'b100000);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", ready, 1'b1);

        // Model pinned against hand-derived streams.
        mbytes = {8'hD2};
        build_model(-1, 1'b0);
        check_str("model_ack", sym_str(), "KJKJKJKKJJKJJKKK00J");
        mbytes = {8'hFF, 8'hFF};
        build_model(-1, 1'b0);
        check("model_ffff_bits", exp_sym.size(), 29);
        mbytes = {8'h3F};
        build_model(-1, 1'b0);
        check_str("model_3f", sym_str(), "KJKJKJKKKKKKKJJKJ00J");

        mbytes = {8'hD2};              run(1'b1, -1, 1'b0, 1'b0, 1);
        mbytes = {8'hFF, 8'hFF};       run(1'b1, -1, 1'b0, 1'b0, 0);
        mbytes = {8'h3F};              run(1'b1, -1, 1'b0, 1'b0, 1);
        mbytes = {8'hA5};              run(1'b0, -1, 1'b1, 1'b1, 2);
        mbytes = {8'h11, 8'h22, 8'h33, 8'h44};
        run(1'b1, 73, 1'b0, 1'b0, 2);  // cancel mid bit 18 (byte 2)
        run(1'b1, 75, 1'b0, 1'b0, 2);  // cancel on the strobe of bit 18
        mbytes = {8'h5A, 8'hC3};
        run(1'b1, 10, 1'b0, 1'b0, 2);  // cancel during SYNC

        // Reset in the middle of DATA, then a clean packet.
        start_cyc = -1;
        send_beat(8'hC3, 1'b1, 1'b1);
        while (cyc - start_cyc < 40) @(negedge clk);
        check("pre_reset {oe,busy}", {oe, busy}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset {dp,dm,oe,busy,ur,ready}", {dp, dm, oe, busy, underrun, ready}, 6'b100000);
        rst = 1'b0;
        @(negedge clk);
        mbytes = {8'hD2};              run(1'b1, -1, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
